// File: rtl/braille_pkg.sv
// Shared types and constants for the Braille number transmitter: cell encoding,
// digit lookup table and FSM state encoding.
package braille_pkg;

  // bit0 = dot1 ... bit5 = dot6; 1 = raised
  typedef logic [5:0] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  localparam cell_t NUM_SIGN = 6'b111100;

  localparam cell_t DIGIT_CELL [0:9] = '{
    6'b011010,  // 0
    6'b000001,  // 1
    6'b000011,  // 2
    6'b001001,  // 3
    6'b011001,  // 4
    6'b010001,  // 5
    6'b001011,  // 6
    6'b011011,  // 7
    6'b010011,  // 8
    6'b001010   // 9
  };

endpackage

// File: rtl/braille_number_transmitter_if.sv
// Request/cell-output bundle between a controller (master) and the Braille
// number transmitter (slave).
interface braille_number_transmitter_if;
  logic       start;
  logic [3:0] X;
  logic [3:0] Y;
  logic       A, B, C, D, E, F;
  logic       cell_valid;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, X, Y,
    input  A, B, C, D, E, F, cell_valid, busy, done, err
  );

  modport slave (
    input  start, X, Y,
    output A, B, C, D, E, F, cell_valid, busy, done, err
  );
endinterface

// File: rtl/bcd_to_braille_cell.sv
// Combinational BCD digit to 6-dot Braille cell lookup; non-BCD codes give a
// blank cell.
module bcd_to_braille_cell
  import braille_pkg::*;
(
  input  logic [3:0] digit_i,
  output cell_t      cell_o
);

  always_comb begin
    cell_o = '0;
    if (digit_i <= 4'd9) begin
      cell_o = DIGIT_CELL[digit_i];
    end
  end

endmodule

// File: rtl/braille_number_transmitter.sv
// Sends a captured two-digit BCD value as numeric-indicator, tens and units
// Braille cells, each held DWELL_CYCLES then blanked for GAP_CYCLES.
// Optional BRAILLE_LZ_SUPPRESS_EN skips the tens cell when the tens digit is 0.
module braille_number_transmitter
  import braille_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  braille_number_transmitter_if.slave  bus
);

  localparam int MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    x_q, x_d, y_q, y_d;
  cell_t         cell_q, cell_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [1:0]    idx_next;
  logic [3:0]    digit_sel;
  cell_t         digit_cell;

  // Skip the tens slot only when suppression is built in and tens is zero
`ifdef BRAILLE_LZ_SUPPRESS_EN
  assign idx_next = ((idx_q == 2'd0) && (x_q == 4'd0)) ? 2'd2 : idx_q + 2'd1;
`else
  assign idx_next = idx_q + 2'd1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.X <= 4'd9) && (bus.Y <= 4'd9)) begin
            x_d     = bus.X;
            y_d     = bus.Y;
            idx_d   = 2'd0;
            cnt_d   = CW'(DWELL_CYCLES - 1);
            state_d = SHOW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (idx_q == 2'd2) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_next;
            cnt_d   = CW'(DWELL_CYCLES - 1);
            state_d = SHOW;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state
  assign digit_sel = (idx_d == 2'd1) ? x_d : y_d;

  bcd_to_braille_cell u_lut (
    .digit_i (digit_sel),
    .cell_o  (digit_cell)
  );

  always_comb begin
    valid_d = (state_d == SHOW);
    busy_d  = (state_d != IDLE);
    cell_d  = '0;
    if (valid_d) begin
      cell_d = (idx_d == 2'd0) ? NUM_SIGN : digit_cell;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      cell_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cell_q  <= cell_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign bus.A          = cell_q[0];
  assign bus.B          = cell_q[1];
  assign bus.C          = cell_q[2];
  assign bus.D          = cell_q[3];
  assign bus.E          = cell_q[4];
  assign bus.F          = cell_q[5];
  assign bus.cell_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_braille_number_transmitter.sv
// Directed bench for braille_number_transmitter with DWELL=4, GAP=2: table of
// digit pairs plus hand-written reset, error, busy-start and back-to-back cases.
module tb_braille_number_transmitter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  braille_number_transmitter_if bus ();

  braille_number_transmitter #(
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [5:0] tens;
    logic [5:0] units;
  } vec_t;

  vec_t vecs [5];

  // {F..A, cell_valid, busy, done, err}
  function automatic logic [9:0] obs();
    return {bus.F, bus.E, bus.D, bus.C, bus.B, bus.A,
            bus.cell_valid, bus.busy, bus.done, bus.err};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [9:0] exp);
    logic [9:0] got;
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got cell=%b valid/busy/done/err=%b, expected cell=%b valid/busy/done/err=%b",
               name, cyc, got[9:4], got[3:0], exp[9:4], exp[3:0]);
    end
  endtask

  task automatic kick(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = x;
    bus.Y     = y;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Checks cycles 1..done after the accepting edge; optionally pulses start
  // with X=mx in cycle 'mid' to verify it is ignored.
  task automatic check_seq(input string name, input logic [3:0] x,
                           input logic [5:0] tens, input logic [5:0] units,
                           input int mid, input logic [3:0] mx);
    logic [5:0] cells [3];
    logic [9:0] exp;
    int n, slot, pos;
    n = 3;
    cells[0] = 6'b111100;
    cells[1] = tens;
    cells[2] = units;
`ifdef BRAILLE_LZ_SUPPRESS_EN
    if (x == 4'd0) begin
      n = 2;
      cells[1] = units;
    end
`endif
    for (int c = 1; c <= n * 6 + 1; c++) begin
      @(negedge clk);
      slot = (c - 1) / 6;
      pos  = (c - 1) % 6;
      exp  = '0;
      if (c <= n * 6) begin
        exp[2] = 1'b1;
        if (pos < 4) begin
          exp[9:4] = cells[slot];
          exp[3]   = 1'b1;
        end
      end else begin
        exp[1] = 1'b1;
      end
      chk(name, c, exp);
      if (c == mid) begin
        bus.start = 1'b1;
        bus.X     = mx;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{x: 4'd4, y: 4'd7, tens: 6'b011001, units: 6'b011011};
    vecs[1] = '{x: 4'd0, y: 4'd5, tens: 6'b011010, units: 6'b010001};
    vecs[2] = '{x: 4'd9, y: 4'd8, tens: 6'b001010, units: 6'b010011};
    vecs[3] = '{x: 4'd6, y: 4'd3, tens: 6'b001011, units: 6'b001001};
    vecs[4] = '{x: 4'd1, y: 4'd2, tens: 6'b000001, units: 6'b000011};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.X     = 4'd0;
    bus.Y     = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_values", 0, 10'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 0, 10'b0);

    for (int i = 0; i < 5; i++) begin
      kick(vecs[i].x, vecs[i].y);
      check_seq($sformatf("vec%0d", i), vecs[i].x, vecs[i].tens, vecs[i].units, 0, 4'd0);
    end

    // Start during busy, with X changed, must not disturb the sequence
    kick(4'd2, 4'd5);
    check_seq("busy_start", 4'd2, 6'b000011, 6'b010001, 8, 4'd9);

    // Non-BCD requests
    kick(4'd10, 4'd3);
    @(negedge clk);
    chk("err_x_pulse", 1, 10'b0000000001);
    @(negedge clk);
    chk("err_x_clear", 2, 10'b0);
    kick(4'd3, 4'd12);
    @(negedge clk);
    chk("err_y_pulse", 1, 10'b0000000001);
    @(negedge clk);
    chk("err_y_clear", 2, 10'b0);

    // Back-to-back: new start in the done cycle
    kick(4'd4, 4'd7);
    check_seq("b2b_first", 4'd4, 6'b011001, 6'b011011, 0, 4'd0);
    bus.start = 1'b1;
    bus.X     = 4'd3;
    bus.Y     = 4'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check_seq("b2b_second", 4'd3, 6'b001001, 6'b011010, 0, 4'd0);

    // Reset mid-operation clears everything at once, with no done pulse
    kick(4'd1, 4'd1);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 5, 10'b0000000100);
    rst = 1'b1;
    #1 chk("reset_async", 5, 10'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", 6 + i, 10'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 9 + i, 10'b0);
    end
    kick(4'd1, 4'd1);
    check_seq("after_reset", 4'd1, 6'b000001, 6'b000001, 0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
